kgp_exec_sequencer: RTL and testbench

Multi-cycle control FSM for the KGP-RISC core. Steps each instruction through fetch, decode, execute, optional memory access and write-back, and owns the architectural PC and the carry/zero/sign flag register. It feeds the registered flags and current PC to the next-PC (branch) logic and commits that logic's PCN result once per instruction. It also sequences the data-memory handshake, including a bounded-wait fault, and supports halt.

---
 rtl/kgp_exec_sequencer_if.sv | 53 +++++
 rtl/kgp_exec_sequencer.sv | 140 ++++++++++++++
 tb/tb_kgp_exec_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/kgp_exec_sequencer_if.sv
// ---------------------------------------------------------------------------
// kgp_exec_sequencer_if
// Bundles every non-clock/reset signal between the KGP-RISC execution
// sequencer and the rest of the core (decoder, ALU, branch logic, data
// memory, register file).
//   master : the sequencer. It drives pc, flags, strobes, status and retired.
//   slave  : the core or testbench side. It drives start, decoded instruction
//            fields, ALU flags, pcn_in and mem_ack.
// ---------------------------------------------------------------------------
interface kgp_exec_sequencer_if #(
  parameter int PC_W = 32
);
  // core -> sequencer
  logic            start;
  logic [2:0]      opcode;
  logic [3:0]      func_code;
  logic            is_load;
  logic            is_store;
  logic            sets_flags;
  logic            alu_carry;
  logic            alu_zero;
  logic            alu_sign;
  logic [PC_W-1:0] pcn_in;
  logic            mem_ack;
  // sequencer -> core
  logic [PC_W-1:0] pc;
  logic            carry_flag;
  logic            zero_flag;
  logic            sign_flag;
  logic            ir_load;
  logic            mem_req;
  logic            reg_we;
  logic            link_we;
  logic [PC_W-1:0] link_data;
  logic            busy;
  logic            halted;
  logic            fault;
  logic [31:0]     retired;

  modport master (
    input  start, opcode, func_code, is_load, is_store, sets_flags,
           alu_carry, alu_zero, alu_sign, pcn_in, mem_ack,
    output pc, carry_flag, zero_flag, sign_flag, ir_load, mem_req,
           reg_we, link_we, link_data, busy, halted, fault, retired
  );

  modport slave (
    output start, opcode, func_code, is_load, is_store, sets_flags,
           alu_carry, alu_zero, alu_sign, pcn_in, mem_ack,
    input  pc, carry_flag, zero_flag, sign_flag, ir_load, mem_req,
           reg_we, link_we, link_data, busy, halted, fault, retired
  );
endinterface

// File: rtl/kgp_exec_sequencer.sv
// ---------------------------------------------------------------------------
// kgp_exec_sequencer
// Multi-cycle control FSM of the KGP-RISC core. It steps each instruction
// through FETCH, DECODE, EXEC, the optional MEM state and WB. It owns the
// architectural PC, the carry/zero/sign flags and the retired-instruction
// counter. The data-memory wait in MEM is bounded by MEM_TIMEOUT cycles; if
// the bound is exceeded the sequencer enters a sticky FAULT state.
// Ports:
//   clk  : rising-edge clock for all state
//   rst  : synchronous, active-high reset
//   bus  : kgp_exec_sequencer_if.master. Carries the instruction fields, the
//          ALU flags, pcn_in and mem_ack in, and pc, the flags, the strobes,
//          the status bits and retired out.
// ---------------------------------------------------------------------------
module kgp_exec_sequencer #(
  parameter int PC_W        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  kgp_exec_sequencer_if.master  bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     retired_q;
  logic            carry_q, zero_q, sign_q;

  logic is_halt_enc;
  assign is_halt_enc = (bus.opcode == 3'b111) && (bus.func_code == 4'b1111);

  // State register and MEM wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = is_halt_enc ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (bus.is_load || bus.is_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // An ack in the last allowed cycle still completes the access.
        if (bus.mem_ack)             state_d = S_WB;
        else if (wait_q == WAIT_LAST) state_d = S_FAULT;
        else                          wait_d  = wait_q + CNT_W'(1);
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Architectural state: flags latch on EXEC exit, PC/retired commit in WB
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      retired_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
    end else begin
      if (state_q == S_EXEC && bus.sets_flags) begin
        carry_q <= bus.alu_carry;
        zero_q  <= bus.alu_zero;
        sign_q  <= bus.alu_sign;
      end
      if (state_q == S_WB) begin
        pc_q      <= bus.pcn_in;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Moore-decoded outputs
  always_comb begin
    bus.ir_load = 1'b0;
    bus.mem_req = 1'b0;
    bus.reg_we  = 1'b0;
    bus.link_we = 1'b0;
    bus.busy    = 1'b1;
    bus.halted  = 1'b0;
    bus.fault   = 1'b0;
    case (state_q)
      S_IDLE:  bus.busy = 1'b0;
      S_FETCH: bus.ir_load = 1'b1;
      S_MEM:   bus.mem_req = 1'b1;
      S_WB: begin
        // Branch-class opcodes (011/100/101) and stores write no register.
        bus.reg_we  = !bus.is_store &&
                      !(bus.opcode == 3'b011 || bus.opcode == 3'b100 ||
                        bus.opcode == 3'b101);
        bus.link_we = (bus.opcode == 3'b011) && (bus.func_code == 4'b0001);
      end
      S_HALT: begin
        bus.busy   = 1'b0;
        bus.halted = 1'b1;
      end
      S_FAULT: begin
        bus.busy  = 1'b0;
        bus.fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.link_data  = pc_q + PC_W'(1);
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.sign_flag  = sign_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_kgp_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kgp_exec_sequencer
// Runs a table of instruction records through the sequencer, one record per
// instruction. Each record holds the decoded fields, the ALU flags, pcn_in and
// the MEM-cycle number in which to ack, together with hand-computed
// expectations. Hand-written sequences then cover reset values, the memory
// timeout fault, the stickiness of HALT and FAULT, and rst mid-instruction.
// ---------------------------------------------------------------------------
module tb_kgp_exec_sequencer;
  localparam int PC_W = 32;
  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kgp_exec_sequencer_if #(.PC_W(PC_W)) bus ();

  kgp_exec_sequencer #(.PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  fc;
    logic        ld, st, sf, c, z, s;
    logic [31:0] pcn;
    int          ack_at;      // MEM cycle number in which to ack, 0 = never
    int          exp_cyc;     // cycles from FETCH until next FETCH/HALT/FAULT
    int          exp_mreq;
    int          exp_rwe;
    int          exp_lwe;
    logic [31:0] exp_pc;
    logic [31:0] exp_link;
    logic [31:0] exp_ret;
    logic        exp_c, exp_z, exp_s, exp_halt, exp_fault;
  } vec_t;

  vec_t vecs [11];

  int tests = 0;
  int fails = 0;

  // Observations from run_instr
  int          obs_cyc, obs_mreq, obs_rwe, obs_lwe, obs_busy_low;
  logic [31:0] obs_link, obs_pc, obs_ret;
  logic        obs_c, obs_z, obs_s, obs_halt, obs_fault;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle_inputs();
    bus.start = 1'b0; bus.opcode = 3'b000; bus.func_code = 4'b0000;
    bus.is_load = 1'b0; bus.is_store = 1'b0; bus.sets_flags = 1'b0;
    bus.alu_carry = 1'b0; bus.alu_zero = 1'b0; bus.alu_sign = 1'b0;
    bus.pcn_in = '0; bus.mem_ack = 1'b0;
  endtask

  // Called just after a falling edge while the DUT is in FETCH. Steps one
  // instruction and returns at the falling edge of the following
  // FETCH/HALT/FAULT cycle. The WB values are those of the last busy cycle.
  task automatic run_instr(input vec_t v);
    int n;
    bus.opcode = v.op; bus.func_code = v.fc;
    bus.is_load = v.ld; bus.is_store = v.st; bus.sets_flags = v.sf;
    bus.alu_carry = v.c; bus.alu_zero = v.z; bus.alu_sign = v.s;
    bus.pcn_in = v.pcn; bus.mem_ack = 1'b0;
    obs_mreq = 0; obs_rwe = 0; obs_lwe = 0; obs_busy_low = 0; obs_link = '0;
    n = 0;
    while (1) begin
      #1;
      if (n > 0 && (bus.ir_load || bus.halted || bus.fault)) break;
      if (n >= 60) break;
      obs_mreq += int'(bus.mem_req);
      obs_rwe  += int'(bus.reg_we);
      obs_lwe  += int'(bus.link_we);
      if (!bus.busy) obs_busy_low++;
      if (bus.link_we) obs_link = bus.link_data;
      obs_c = bus.carry_flag; obs_z = bus.zero_flag; obs_s = bus.sign_flag;
      bus.mem_ack = bus.mem_req && (v.ack_at != 0) && (obs_mreq == v.ack_at);
      n++;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    obs_cyc = n;
    obs_pc = bus.pc; obs_ret = bus.retired;
    obs_halt = bus.halted; obs_fault = bus.fault;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    chk({p, ".cycles"},  64'(obs_cyc),  64'(v.exp_cyc));
    chk({p, ".mem_req"}, 64'(obs_mreq), 64'(v.exp_mreq));
    chk({p, ".reg_we"},  64'(obs_rwe),  64'(v.exp_rwe));
    chk({p, ".link_we"}, 64'(obs_lwe),  64'(v.exp_lwe));
    chk({p, ".busy"},    64'(obs_busy_low), 64'(0));
    if (v.exp_lwe != 0) chk({p, ".link_data"}, 64'(obs_link), 64'(v.exp_link));
    chk({p, ".pc"},      64'(obs_pc),   64'(v.exp_pc));
    chk({p, ".retired"}, 64'(obs_ret),  64'(v.exp_ret));
    chk({p, ".flags"},   64'({obs_c, obs_z, obs_s}), 64'({v.exp_c, v.exp_z, v.exp_s}));
    chk({p, ".halted"},  64'(obs_halt), 64'(v.exp_halt));
    chk({p, ".fault"},   64'(obs_fault), 64'(v.exp_fault));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_state(input string p);
    chk({p, ".pc"},       64'(bus.pc), 64'(0));
    chk({p, ".flags"},    64'({bus.carry_flag, bus.zero_flag, bus.sign_flag}), 64'(0));
    chk({p, ".retired"},  64'(bus.retired), 64'(0));
    chk({p, ".strobes"},  64'({bus.ir_load, bus.mem_req, bus.reg_we, bus.link_we}), 64'(0));
    chk({p, ".status"},   64'({bus.busy, bus.halted, bus.fault}), 64'(0));
    chk({p, ".link_data"}, 64'(bus.link_data), 64'(1));
  endtask

  // Pulse start from IDLE and return just after the falling edge in FETCH.
  task automatic start_run();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("start.ir_load", 64'(bus.ir_load), 64'(1));
  endtask

  initial begin
    vec_t v;
    //             op      fc      ld st sf c z s  pcn    ack cyc mrq rwe lwe pc     link  ret  c z s h f
    vecs[0]  = '{3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 32'h01,  0,  4,  0,  1,  0, 32'h01, 32'h0, 1,  0, 0, 0, 0, 0};
    vecs[1]  = '{3'b000, 4'b0001, 0, 0, 0, 0, 0, 0, 32'h02,  0,  4,  0,  1,  0, 32'h02, 32'h0, 2,  0, 0, 0, 0, 0};
    vecs[2]  = '{3'b000, 4'b0010, 0, 0, 0, 0, 0, 0, 32'h03,  0,  4,  0,  1,  0, 32'h03, 32'h0, 3,  0, 0, 0, 0, 0};
    vecs[3]  = '{3'b000, 4'b0010, 0, 0, 1, 1, 0, 1, 32'h10,  0,  4,  0,  1,  0, 32'h10, 32'h0, 4,  1, 0, 1, 0, 0};
    vecs[4]  = '{3'b011, 4'b0001, 0, 0, 0, 0, 1, 0, 32'h40,  0,  4,  0,  0,  1, 32'h40, 32'h11, 5, 1, 0, 1, 0, 0};
    vecs[5]  = '{3'b011, 4'b0010, 0, 0, 0, 0, 0, 0, 32'h45,  0,  4,  0,  0,  0, 32'h45, 32'h0, 6,  1, 0, 1, 0, 0};
    vecs[6]  = '{3'b001, 4'b0000, 1, 0, 0, 0, 0, 0, 32'h46,  3,  7,  3,  1,  0, 32'h46, 32'h0, 7,  1, 0, 1, 0, 0};
    vecs[7]  = '{3'b010, 4'b0000, 0, 1, 0, 0, 0, 0, 32'h47, 15, 19, 15,  0,  0, 32'h47, 32'h0, 8,  1, 0, 1, 0, 0};
    vecs[8]  = '{3'b001, 4'b0000, 1, 0, 0, 0, 0, 0, 32'h04,  1,  5,  1,  1,  0, 32'h04, 32'h0, 9,  1, 0, 1, 0, 0};
    vecs[9]  = '{3'b100, 4'b0000, 0, 0, 1, 0, 1, 0, 32'h05,  0,  4,  0,  0,  0, 32'h05, 32'h0, 10, 0, 1, 0, 0, 0};
    vecs[10] = '{3'b111, 4'b1111, 0, 0, 0, 0, 0, 0, 32'h99,  0,  2,  0,  0,  0, 32'h05, 32'h0, 10, 0, 1, 0, 1, 0};

    // Reset values, then the instruction stream
    do_reset();
    check_reset_state("reset");
    start_run();
    chk("start.pc", 64'(bus.pc), 64'(0));
    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i]);
      check_vec(i, vecs[i]);
    end

    // HALT is sticky and ignores start
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    bus.start = 1'b0;
    chk("halt.sticky", 64'({bus.halted, bus.busy, bus.ir_load}), 64'(3'b100));
    chk("halt.pc", 64'(bus.pc), 64'(5));
    chk("halt.retired", 64'(bus.retired), 64'(10));

    // Store whose ack never arrives: 15 MEM cycles, then sticky FAULT
    do_reset();
    check_reset_state("reset2");
    start_run();
    v = '{3'b010, 4'b0000, 0, 1, 0, 0, 0, 0, 32'h33, 0, 18, 15, 0, 0,
          32'h0, 32'h0, 0, 0, 0, 0, 0, 1};
    run_instr(v);
    check_vec(100, v);
    bus.start = 1'b1;
    bus.mem_ack = 1'b1;   // late ack outside MEM must not revive anything
    repeat (5) @(negedge clk);
    #1;
    bus.start = 1'b0;
    bus.mem_ack = 1'b0;
    chk("fault.sticky", 64'({bus.fault, bus.busy, bus.mem_req, bus.halted}), 64'(4'b1000));
    chk("fault.pc", 64'(bus.pc), 64'(0));

    // rst during EXEC of a load that follows a flag-setting ALU op
    do_reset();
    start_run();
    v = '{3'b000, 4'b0000, 0, 0, 1, 1, 1, 1, 32'h20, 0, 4, 0, 1, 0,
          32'h20, 32'h0, 1, 1, 1, 1, 0, 0};
    run_instr(v);
    check_vec(200, v);
    bus.opcode = 3'b001; bus.is_load = 1'b1; bus.sets_flags = 1'b1;
    bus.alu_carry = 1'b0; bus.alu_zero = 1'b0; bus.alu_sign = 1'b0;
    bus.pcn_in = 32'h21;
    @(negedge clk);           // DECODE
    @(negedge clk);           // EXEC
    #1;
    chk("rst.in_exec_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_state("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.stays_idle", 64'({bus.busy, bus.mem_req, bus.pc}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
